// File: rtl/kpscan.sv
// kpscan -- 4x4 keypad scanner / debouncer for the TicTacToe input path.
//
// Drives one keypad column low at a time. The raw row lines are
// synchronized and debounced. The block then presents a stable
// column/row pair to the downstream key decoder, and pulses kpevent
// once for each accepted press.
//
// Ports
//   clk      in  1  system clock, all state on the rising edge
//   reset_n  in  1  asynchronous active-low reset
//   kpr_raw  in  4  raw row pins, active-low, asynchronous to clk
//   kpc      out 4  column drive, one-hot-low (also the decoder column)
//   kpr      out 4  debounced row pattern, 4'b1111 when no key is held
//   kpevent  out 1  one-cycle pulse per accepted press
//
// Parameters
//   SCAN_DIV       cycles each column is driven while scanning (>= 4)
//   DEBOUNCE       consecutive stable cycles to accept press/release (>= 2)
//   REPEAT_CYCLES  auto-repeat period (used only with the macro below)
//
// Build option
//   KPSCAN_AUTOREPEAT_EN  when defined, a held key re-pulses kpevent
//                         every REPEAT_CYCLES cycles spent in HOLD.
module kpscan #(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE      = 8,
    parameter int REPEAT_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr_raw,
    output logic [3:0] kpc,
    output logic [3:0] kpr,
    output logic       kpevent
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(DEBOUNCE - 1);
    localparam logic [3:0]    NOKEY     = 4'b1111;
    localparam logic [3:0]    COL0      = 4'b0111;

    if (SCAN_DIV < 4 || DEBOUNCE < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("kpscan: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t          r_state, w_next;
    logic [3:0]      r_sync1, r_row_s;
    logic [DW-1:0]   r_dcnt, w_dcnt;
    logic [BW-1:0]   r_bcnt, w_bcnt;
    logic [3:0]      r_pat, w_pat;
    logic [3:0]      r_kpc, w_kpc;
    logic [3:0]      r_kpr, w_kpr;
    logic            r_kpevent, w_kpevent;
    logic [3:0]      w_kpc_next;

`ifdef KPSCAN_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]   r_rcnt, w_rcnt;
`endif

    // Two-flop synchronizer; every decision below looks only at r_row_s.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= NOKEY;
            r_row_s <= NOKEY;
        end else begin
            r_sync1 <= kpr_raw;
            r_row_s <= r_sync1;
        end
    end

    // Column order 0111 -> 1011 -> 1101 -> 1110 -> 0111 is a right rotate.
    assign w_kpc_next = {r_kpc[0], r_kpc[3:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_SCAN;
            r_dcnt    <= '0;
            r_bcnt    <= '0;
            r_pat     <= NOKEY;
            r_kpc     <= COL0;
            r_kpr     <= NOKEY;
            r_kpevent <= 1'b0;
`ifdef KPSCAN_AUTOREPEAT_EN
            r_rcnt    <= '0;
`endif
        end else begin
            r_state   <= w_next;
            r_dcnt    <= w_dcnt;
            r_bcnt    <= w_bcnt;
            r_pat     <= w_pat;
            r_kpc     <= w_kpc;
            r_kpr     <= w_kpr;
            r_kpevent <= w_kpevent;
`ifdef KPSCAN_AUTOREPEAT_EN
            r_rcnt    <= w_rcnt;
`endif
        end
    end

    always_comb begin
        w_next    = r_state;
        w_dcnt    = r_dcnt;
        w_bcnt    = r_bcnt;
        w_pat     = r_pat;
        w_kpc     = r_kpc;
        w_kpr     = r_kpr;
        w_kpevent = 1'b0;
`ifdef KPSCAN_AUTOREPEAT_EN
        w_rcnt    = r_rcnt;
`endif
        case (r_state)
            S_SCAN: begin
                if (r_dcnt == DCNT_LAST) begin
                    if (r_row_s != NOKEY) begin
                        // Freeze on this column and start qualifying the pattern.
                        w_pat  = r_row_s;
                        w_bcnt = '0;
                        w_next = S_DEBOUNCE;
                    end else begin
                        w_kpc  = w_kpc_next;
                        w_dcnt = '0;
                    end
                end else begin
                    w_dcnt = r_dcnt + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (r_row_s == r_pat) begin
                    if (r_bcnt == BCNT_LAST) begin
                        // Registered kpevent lands in the first HOLD cycle.
                        w_next    = S_HOLD;
                        w_kpr     = r_pat;
                        w_kpevent = 1'b1;
`ifdef KPSCAN_AUTOREPEAT_EN
                        w_rcnt    = '0;
`endif
                    end else begin
                        w_bcnt = r_bcnt + 1'b1;
                    end
                end else begin
                    // Bounce: rescan the same column from the start of its dwell.
                    w_next = S_SCAN;
                    w_dcnt = '0;
                end
            end
            S_HOLD: begin
                if (r_row_s == NOKEY) begin
                    w_bcnt = '0;
                    w_next = S_RELEASE;
`ifdef KPSCAN_AUTOREPEAT_EN
                    w_rcnt = '0;
`endif
                end else begin
                    // A different non-idle pattern is ignored; r_pat is held.
`ifdef KPSCAN_AUTOREPEAT_EN
                    if (r_rcnt == RCNT_LAST) begin
                        w_kpevent = 1'b1;
                        w_rcnt    = '0;
                    end else begin
                        w_rcnt = r_rcnt + 1'b1;
                    end
`endif
                end
            end
            S_RELEASE: begin
                if (r_row_s == NOKEY) begin
                    if (r_bcnt == BCNT_LAST) begin
                        w_next = S_SCAN;
                        w_kpr  = NOKEY;
                        w_kpc  = w_kpc_next;
                        w_dcnt = '0;
                    end else begin
                        w_bcnt = r_bcnt + 1'b1;
                    end
                end else begin
                    // Release bounce: back to HOLD silently, repeat timer restarts.
                    w_next = S_HOLD;
                    w_bcnt = '0;
`ifdef KPSCAN_AUTOREPEAT_EN
                    w_rcnt = '0;
`endif
                end
            end
            default: begin
                w_next = S_SCAN;
            end
        endcase
    end

    assign kpc     = r_kpc;
    assign kpr     = r_kpr;
    assign kpevent = r_kpevent;

endmodule

// File: tb/tb_kpscan.sv
// Self-checking bench for kpscan: directed scenarios with literal
// expectations plus a randomized row-pin stream, all compared every
// cycle against a behavioural model of the keypad front end.
module tb_kpscan;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int RC = 20;
    localparam logic [3:0] NOKEY = 4'b1111;
`ifdef KPSCAN_AUTOREPEAT_EN
    localparam int EXP_STEADY_EV = 4;
`else
    localparam int EXP_STEADY_EV = 1;
`endif

    localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2, M_REL = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpr_raw = 4'b1111;
    logic [3:0] kpc, kpr;
    logic       kpevent;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: column as an index, hold age as a free-running count.
    logic [3:0] m_s1, m_s2, m_pat;
    int         m_mode, m_col, m_dwell, m_stab, m_age;
    bit         m_ev;

    kpscan #(.SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_CYCLES(RC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kpr_raw (kpr_raw),
        .kpc     (kpc),
        .kpr     (kpr),
        .kpevent (kpevent)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_s1 = NOKEY; m_s2 = NOKEY; m_pat = NOKEY;
        m_mode = M_SCAN; m_col = 0; m_dwell = 0; m_stab = 0; m_age = 0;
        m_ev = 1'b0;
    endtask

    // One clock edge of the keypad behaviour, driven from the pins it sees.
    task automatic model_edge();
        logic [3:0] row;
        row  = m_s2;
        m_s2 = m_s1;
        m_s1 = kpr_raw;
        m_ev = 1'b0;
        case (m_mode)
            M_SCAN:
                if (m_dwell == SD - 1) begin
                    if (row != NOKEY) begin
                        m_pat = row; m_stab = 0; m_mode = M_DEB;
                    end else begin
                        m_col = (m_col + 1) % 4; m_dwell = 0;
                    end
                end else m_dwell++;
            M_DEB:
                if (row == m_pat) begin
                    if (m_stab == DB - 1) begin
                        m_mode = M_HOLD; m_age = 0; m_ev = 1'b1;
                    end else m_stab++;
                end else begin
                    m_mode = M_SCAN; m_dwell = 0;
                end
            M_HOLD:
                if (row == NOKEY) begin
                    m_mode = M_REL; m_stab = 0;
                end else begin
                    m_age++;
`ifdef KPSCAN_AUTOREPEAT_EN
                    if (m_age % RC == 0) m_ev = 1'b1;
`endif
                end
            default:
                if (row == NOKEY) begin
                    if (m_stab == DB - 1) begin
                        m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
                    end else m_stab++;
                end else begin
                    m_mode = M_HOLD; m_stab = 0; m_age = 0;
                end
        endcase
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] t;
        t = 4'b1000;
        return ~(t >> c);
    endfunction

    function automatic logic [3:0] exp_kpr();
        return (m_mode == M_HOLD || m_mode == M_REL) ? m_pat : NOKEY;
    endfunction

    // Compare process: every cycle the bench has marked meaningful.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (kpc !== col_drive(m_col) || kpr !== exp_kpr() || kpevent !== m_ev) begin
                errors++;
                $display("FAIL model t=%0t kpc got %b exp %b kpr got %b exp %b kpevent got %b exp %b",
                         $time, kpc, col_drive(m_col), kpr, exp_kpr(), kpevent, m_ev);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Idle the pins until kpc freshly arrives at tgt (start of its dwell).
    task automatic wait_col(input logic [3:0] tgt);
        int n;
        n = 0;
        kpr_raw = NOKEY;
        while (kpc == tgt && n < 64) begin tick(); n++; end
        while (kpc != tgt && n < 64) begin tick(); n++; end
        check("wait_col", kpc, tgt);
    endtask

    initial begin
        int ev_cnt, first_ev, len, r;
        bit kpr_moved;
        logic [3:0] v, kpc_at_rel;

        // Reset, no key.
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_kpc", kpc, 4'b0111);
        check("rst_kpr", kpr, 4'b1111);
        check("rst_kpevent", kpevent, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Idle scan: each column for 4 cycles, 16-cycle period.
        for (int k = 1; k <= 32; k++) begin
            tick();
            check("scan_kpc", kpc, col_drive((k / 4) % 4));
        end

        // Steady press of row 2 on column 1 (key 8 for the decoder).
        wait_col(4'b1011);
        kpr_raw = 4'b1101;
        ev_cnt = 0; first_ev = -1;
        for (int i = 1; i <= 85; i++) begin
            tick();
            if (kpevent) begin
                ev_cnt++;
                if (first_ev < 0) first_ev = i;
            end
        end
        // 2 sync + 2 remaining dwell edges to the decision, then 8 debounce edges.
        check("press_first_ev", first_ev, 12);
        check("press_ev_count", ev_cnt, EXP_STEADY_EV);
        check("press_kpc", kpc, 4'b1011);
        check("press_kpr", kpr, 4'b1101);

        // Release with 3-cycle low glitches, then a clean release.
        ev_cnt = 0;
        for (int g = 0; g < 2; g++) begin
            kpr_raw = NOKEY;
            repeat (5) begin tick(); if (kpevent) ev_cnt++; end
            kpr_raw = 4'b1101;
            repeat (3) begin tick(); if (kpevent) ev_cnt++; end
        end
        check("relbounce_kpr_held", kpr, 4'b1101);
        kpr_raw = NOKEY;
        kpc_at_rel = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (kpevent) ev_cnt++;
            if (kpr == NOKEY && kpc_at_rel == 4'b0000) kpc_at_rel = kpc;
        end
        check("release_ev", ev_cnt, 0);
        check("release_kpc_next", kpc_at_rel, 4'b1101);
        check("release_kpr", kpr, 4'b1111);

        // Press bounce: 1101/1111 toggling every 3 cycles never qualifies.
        wait_col(4'b1011);
        ev_cnt = 0; kpr_moved = 1'b0;
        for (int t = 0; t < 4; t++) begin
            kpr_raw = 4'b1101;
            repeat (3) begin tick(); if (kpevent) ev_cnt++; if (kpr != NOKEY) kpr_moved = 1'b1; end
            kpr_raw = NOKEY;
            repeat (3) begin tick(); if (kpevent) ev_cnt++; if (kpr != NOKEY) kpr_moved = 1'b1; end
        end
        repeat (8) tick();
        check("pbounce_ev", ev_cnt, 0);
        check("pbounce_kpr_moved", kpr_moved, 0);

        // Mid-operation reset while a key is held.
        wait_col(4'b1110);
        kpr_raw = 4'b1110;
        repeat (20) tick();
        check("hold_kpr", kpr, 4'b1110);
        chk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_kpc", kpc, 4'b0111);
        check("midrst_kpr", kpr, 4'b1111);
        check("midrst_kpevent", kpevent, 0);
        model_reset();
        kpr_raw = NOKEY;
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (4) tick();
        check("midrst_rescan", kpc, 4'b1011);

        // Randomized row-pin stream: idle, single-row and arbitrary patterns.
        for (int s = 0; s < 160; s++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      v = NOKEY;
            else if (r < 8) v = ~(4'b0001 << $urandom_range(0, 3));
            else            v = 4'($urandom);
            kpr_raw = v;
            len = $urandom_range(1, 30);
            repeat (len) tick();
        end
        kpr_raw = NOKEY;
        repeat (40) tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kpscan.md
# kpscan

Keypad front end for the TicTacToe board input path. Drives the 4x4 keypad columns one at a time (active-low), synchronizes and debounces the raw row lines, and holds a stable column/row pair for the downstream keypad decoder. The decoder turns that pair into a key number and hit flag. Also emits a one-cycle `kpevent` pulse per debounced press so game logic registers each press exactly once.

## Interface
- `SCAN_DIV`, default 4: cycles each column is driven during scanning; legal minimum 4.
- `DEBOUNCE`, default 8: consecutive stable cycles required to accept a press or a release; legal minimum 2.
- `REPEAT_CYCLES`, default 20: auto-repeat period; used only when auto-repeat is compiled in.
- `clk` in 1: system clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `kpr_raw` in 4: raw keypad row pins, active-low, asynchronous to `clk`.
- `kpc` out 4: column drive, one-hot-low; also feeds the decoder column input.
- `kpr` out 4: debounced row pattern to the decoder; `4'b1111` when no accepted key.
- `kpevent` out 1: single-cycle pulse on each accepted press.

## Operation
- `kpr_raw` passes through a 2-flop synchronizer to give `row_s`. All decisions use `row_s` only.
- States: SCAN, DEBOUNCE, HOLD, RELEASE. Internal registers: `dcnt` (dwell counter), `bcnt` (debounce counter), `pat` (latched row pattern).
- SCAN:
  - `kpr`=1111 and `dcnt` counts 0..SCAN_DIV-1.
  - At `dcnt`=SCAN_DIV-1 with `row_s`≠1111: latch `pat`=`row_s`, clear `bcnt`, go to DEBOUNCE; `kpc` stays frozen.
  - At `dcnt`=SCAN_DIV-1 otherwise: rotate `kpc` 0111→1011→1101→1110→0111 and clear `dcnt`.
- DEBOUNCE:
  - Each cycle with `row_s`==`pat` increments `bcnt`. When that happens with `bcnt`=DEBOUNCE-1, go to HOLD.
  - Any cycle with `row_s`≠`pat` returns to SCAN with `dcnt`=0. The same column is rescanned; `kpc` is unchanged.
- HOLD:
  - `kpr`=`pat` and `kpc` frozen. `kpevent`=1 in the first HOLD cycle only.
  - `row_s`==1111 clears `bcnt` and goes to RELEASE.
  - `row_s` changing to a different non-1111 value is ignored; `pat` is held.
- RELEASE:
  - `kpr`=`pat` still. Each cycle with `row_s`==1111 increments `bcnt`.
  - At `bcnt`=DEBOUNCE-1 on a 1111 cycle: go to SCAN, set `kpr`=1111, advance `kpc` to the next column, `dcnt`=0.
  - Any `row_s`≠1111 returns to HOLD with `bcnt`=0. No new `kpevent`.
- Multi-row patterns (more than one zero) are latched as-is. The decoder treats them as no valid key.
- Counters saturate by construction; none wraps.

## Timing
- Reset values: `kpc`=0111, `kpr`=1111, `kpevent`=0, state SCAN, `dcnt`=`bcnt`=0, `pat`=1111, synchronizer flops=1111.
- Asynchronous reset: all outputs take reset values immediately on `reset_n` falling, in any state.
- Synchronizer latency: 2 cycles from `kpr_raw` to `row_s`.
- Press timing: if the SCAN→DEBOUNCE decision is made at edge T, `kpr` becomes `pat` and `kpevent` pulses in the cycle after edge T+DEBOUNCE, with an uninterrupted match.
- Release timing: `kpr` returns to 1111 DEBOUNCE cycles after `row_s` first reads 1111, with no bounce.
- Full scan period with no key: 4×SCAN_DIV cycles.
- `kpc` and `kpr` are registered outputs; no combinational path from `kpr_raw`.

## Configuration
- `KPSCAN_AUTOREPEAT_EN` defined:
  - In HOLD, a repeat counter runs from entry.
  - `kpevent` pulses again every REPEAT_CYCLES cycles: at HOLD entry+REPEAT_CYCLES, +2×REPEAT_CYCLES, and so on.
  - The counter clears on leaving HOLD. A RELEASE→HOLD bounce restarts it without pulsing.
- `KPSCAN_AUTOREPEAT_EN` undefined: exactly one `kpevent` per accepted press; repeat counter and `REPEAT_CYCLES` logic absent.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=8.
- Reset, no key: `kpc`=0111, `kpr`=1111, `kpevent`=0. `kpc` then cycles 0111,1011,1101,1110 with 4 cycles each, repeating every 16 cycles.
- Steady press: drive `kpr_raw`=1101 while `kpc`=1011 and hold it. `kpc` freezes at 1011 and `kpr`=1101 after debounce. Exactly one `kpevent`; the downstream decoder reads key 8.
- Press bounce: `kpr_raw` toggles 1101/1111 every 3 cycles during DEBOUNCE. No `kpevent`, `kpr` stays 1111, scanning resumes at `kpc`=1011.
- Release bounce: from HOLD, the row goes high with 3-cycle glitches low. `kpr` stays 1101 until 8 consecutive high cycles, then `kpr`=1111 and `kpc`=1101, with no extra `kpevent`.
- Mid-operation reset: assert `reset_n`=0 in HOLD. `kpc`=0111, `kpr`=1111, `kpevent`=0 immediately; scanning restarts after `reset_n`=1.
- Auto-repeat, with `KPSCAN_AUTOREPEAT_EN` and REPEAT_CYCLES=20: hold the key for 70 cycles after acceptance. `kpevent` pulses at +0, +20, +40 and +60. Without the macro, only the +0 pulse occurs.
